// File: rtl/ror_seq_pkg.sv
// Shared types and widths for the sequential rotate unit.
package ror_seq_pkg;
  localparam int DATA_W = 32;
  localparam int AMT_W  = 5;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} ror_state_t;
  typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/ror_step.sv
// Combinational rotate of one word by a small amount (0..STEP).
// With ROR_SEQ_DIR_EN defined a direction input selects rotate-left.
module ror_step
  import ror_seq_pkg::*;
(
  input  word_t            data,
  input  logic [AMT_W-1:0] amt,
`ifdef ROR_SEQ_DIR_EN
  input  logic             dir,
`endif
  output word_t            rot
);
  // amt==0 makes the complementary shift 32, which yields zero: plain pass-through.
  logic [AMT_W:0] inv;
  assign inv = (AMT_W+1)'(DATA_W) - {1'b0, amt};

`ifdef ROR_SEQ_DIR_EN
  assign rot = dir ? ((data << amt) | (data >> inv))
                   : ((data >> amt) | (data << inv));
`else
  assign rot = (data >> amt) | (data << inv);
`endif
endmodule

// File: rtl/ror_seq_32bit.sv
// Multi-cycle 32-bit rotate-right unit, up to STEP bits per clock, valid/ready on
// both sides. Define ROR_SEQ_DIR_EN to add in_dir (1 = rotate left).
module ror_seq_32bit #(
  parameter int DATA_W = 32,
  parameter int STEP   = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [4:0]        in_amt,
`ifdef ROR_SEQ_DIR_EN
  input  logic              in_dir,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);
  import ror_seq_pkg::*;

  if (DATA_W != 32) begin : g_bad_width
    $error("ror_seq_32bit: DATA_W must be 32");
  end
  if (STEP < 1 || STEP > 16 || (STEP & (STEP - 1)) != 0) begin : g_bad_step
    $error("ror_seq_32bit: STEP must be a power of 2 in 1..16");
  end

  ror_state_t       state;
  word_t            data_q;
  word_t            step_data;
  logic [AMT_W-1:0] rem;
  logic [AMT_W-1:0] step;
`ifdef ROR_SEQ_DIR_EN
  logic             dir_q;
`endif

  assign step = (rem > AMT_W'(STEP)) ? AMT_W'(STEP) : rem;

  ror_step u_step (
    .data (data_q),
    .amt  (step),
`ifdef ROR_SEQ_DIR_EN
    .dir  (dir_q),
`endif
    .rot  (step_data)
  );

  // data_q only changes outside DONE, so it doubles as the held result.
  assign out_data = data_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      data_q    <= '0;
      rem       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef ROR_SEQ_DIR_EN
      dir_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          data_q   <= in_data;
          rem      <= in_amt;
          in_ready <= 1'b0;
          busy     <= 1'b1;
`ifdef ROR_SEQ_DIR_EN
          dir_q    <= in_dir;
`endif
          if (in_amt == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            state <= BUSY;
          end
        end
        BUSY: begin
          data_q <= step_data;
          rem    <= rem - step;
          if (rem == step) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ror_seq_32bit.sv
// Self-checking bench for ror_seq_32bit: directed literal cases, an amount sweep and
// random traffic, all compared each cycle against a transaction-level model.
module tb_ror_seq_32bit;
  localparam int STEP = 4;

  logic        clock     = 1'b0;
  logic        reset_n   = 1'b0;
  logic        in_valid  = 1'b0;
  logic [31:0] in_data   = '0;
  logic [4:0]  in_amt    = '0;
  logic        in_dir    = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, busy;
  logic [31:0] out_data;

  int checks   = 0;
  int failures = 0;
  bit run_cmp  = 1'b0;

  always #5 clock = ~clock;

  ror_seq_32bit #(.DATA_W(32), .STEP(STEP)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_amt   (in_amt),
`ifdef ROR_SEQ_DIR_EN
    .in_dir   (in_dir),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  // Result bit j comes from source bit (j + r) mod 32, r = right-rotate distance.
  function automatic logic [31:0] rot_ref(input logic [31:0] x, input int a, input bit left);
    logic [63:0] w;
    int r;
    r = left ? ((32 - a) % 32) : a;
    w = {x, x};
    return w[r +: 32];
  endfunction

  function automatic int lat_ref(input int a);
    return (a == 0) ? 1 : 1 + (a + STEP - 1) / STEP;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: phase 0 idle, 1 computing (cnt edges left), 2 result held.
  int          m_phase = 0;
  int          m_cnt   = 0;
  logic [31:0] m_res   = '0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_phase <= 0;
      m_cnt   <= 0;
      m_res   <= '0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_res <= rot_ref(in_data, int'(in_amt), in_dir);
          if (lat_ref(int'(in_amt)) == 1) m_phase <= 2;
          else begin
            m_cnt   <= lat_ref(int'(in_amt)) - 1;
            m_phase <= 1;
          end
        end
        1: begin
          m_cnt <= m_cnt - 1;
          if (m_cnt == 1) m_phase <= 2;
        end
        default: if (out_ready) m_phase <= 0;
      endcase
    end
  end

  always @(negedge clock) begin
    if (reset_n && run_cmp) begin
      chk("cyc_in_ready",  32'(in_ready),  32'(m_phase == 0));
      chk("cyc_busy",      32'(busy),      32'(m_phase != 0));
      chk("cyc_out_valid", 32'(out_valid), 32'(m_phase == 2));
      if (m_phase == 2) chk("cyc_out_data", out_data, m_res);
    end
  end

  task automatic run_op(input string name, input logic [31:0] d, input logic [4:0] a,
                        input bit dir, input logic [31:0] exp, input int lat, input int hold);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk({name, "_ready_wait"}, 32'(in_ready), 32'd1);
    in_data  = d;
    in_amt   = a;
    in_dir   = dir;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    in_data  = $urandom;
    in_amt   = 5'($urandom);
    n = 1;
    while (!out_valid && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk({name, "_latency"}, 32'(n), 32'(lat));
    chk({name, "_data"}, out_data, exp);
    repeat (hold) @(negedge clock);
    chk({name, "_held"}, out_data, exp);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    chk({name, "_in_ready_after"}, 32'(in_ready), 32'd1);
    in_dir = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    repeat (3) @(negedge clock);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_out_data",  out_data,       32'h0);
    reset_n = 1'b1;
    run_cmp = 1'b1;

    // Consumer ready with nothing pending must not disturb idle.
    out_ready = 1'b1;
    repeat (3) @(negedge clock);
    out_ready = 1'b0;

    run_op("t1", 32'h0000_0001, 5'd1,  1'b0, 32'h8000_0000, 2, 0);
    run_op("t2", 32'h0000_00F0, 5'd8,  1'b0, 32'hF000_0000, 3, 0);
    run_op("t3", 32'hDEAD_BEEF, 5'd0,  1'b0, 32'hDEAD_BEEF, 1, 0);
    run_op("t4", 32'h0000_0001, 5'd31, 1'b0, 32'h0000_0002, 9, 5);

    // Reset in the middle of a long rotate.
    in_data  = 32'h1234_5678;
    in_amt   = 5'd20;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (2) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_rst_out_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_out_data",  out_data,       32'h0);
    chk("t5_rst_in_ready",  32'(in_ready),  32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    run_op("t5_next", 32'h0000_000F, 5'd4, 1'b0, 32'hF000_0000, 2, 0);

`ifdef ROR_SEQ_DIR_EN
    run_op("t6_left", 32'h8000_0000, 5'd1, 1'b1, 32'h0000_0001, 2, 0);
`endif

    for (int a = 0; a < 32; a++) begin
      d = $urandom;
      run_op("sweep_r", d, 5'(a), 1'b0, rot_ref(d, a, 1'b0), lat_ref(a), int'($urandom_range(0, 2)));
`ifdef ROR_SEQ_DIR_EN
      d = $urandom;
      run_op("sweep_l", d, 5'(a), 1'b1, rot_ref(d, a, 1'b1), lat_ref(a), int'($urandom_range(0, 2)));
`endif
    end

    // Random traffic: in_valid also toggles while busy and must be ignored.
    for (int c = 0; c < 600; c++) begin
      in_valid  = 1'($urandom);
      in_data   = $urandom;
      in_amt    = 5'($urandom);
`ifdef ROR_SEQ_DIR_EN
      in_dir    = 1'($urandom);
`endif
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clock);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(negedge clock);
    chk("end_idle", 32'(in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
